// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: opcodes, load/store width encodings,
// and the memory-access stage state type.
package riscv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } ma_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic for loads/stores: byte enables, replicated store
// data, misalignment/illegal-width flag and extended load data.
module load_store_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte / halfword out of the returned word
  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Decode width; unsigned widths are illegal for stores, unknown widths always
  always_comb begin
    be       = 4'b1111;
    wdata    = rs2;
    misalign = 1'b0;
    ld_data  = rdata;
    case (funct3)
      F3_B: begin
        be      = 4'b0001 << addr_lo;
        wdata   = {4{rs2[7:0]}};
        ld_data = {{24{byte_lane[7]}}, byte_lane};
      end
      F3_H: begin
        be       = 4'b0011 << addr_lo;
        wdata    = {2{rs2[15:0]}};
        misalign = addr_lo[0];
        ld_data  = {{16{half_lane[15]}}, half_lane};
      end
      F3_W: misalign = |addr_lo;
      F3_BU: begin
        misalign = is_store;
        ld_data  = {24'b0, byte_lane};
      end
      F3_HU: begin
        misalign = is_store | addr_lo[0];
        ld_data  = {16'b0, half_lane};
      end
      default: misalign = 1'b1;
    endcase
    // Loads always fetch the full word; lane selection happens on return
    if (!is_store) be = 4'b1111;
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: forwards ALU results in one cycle and runs
// loads/stores over a req/ack data-memory port with a timeout.
module mem_access
  import riscv_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        valid_R1,
  input  logic [31:0] alu_result_R1,
  input  logic [31:0] rs2_data_R1,
  input  logic [31:0] instruction_fetched_R1,
  input  logic [4:0]  rd_1,
  output logic        stall_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] data_out_exe_R2,
  output logic [31:0] instruction_fetched_R2,
  output logic [4:0]  rd_2,
  output logic        misalign_err,
  output logic        bus_err
);

  ma_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  alo_q, alo_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] r2_data_q, r2_data_d, r2_instr_q, r2_instr_d;
  logic [4:0]  r2_rd_q, r2_rd_d;
  logic        mis_q, mis_d, bus_q, bus_d;
  logic        stall;

  // In IDLE the lane logic looks at the incoming instruction; while waiting
  // it looks at the latched one so the returned word is extended correctly.
  logic        in_idle, is_load, is_store, misalign;
  logic [6:0]  cur_op;
  logic [2:0]  cur_f3;
  logic [1:0]  cur_alo;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ld_data;

  assign in_idle  = (state_q == IDLE);
  assign cur_op   = in_idle ? instruction_fetched_R1[6:0]   : instr_q[6:0];
  assign cur_f3   = in_idle ? instruction_fetched_R1[14:12] : instr_q[14:12];
  assign cur_alo  = in_idle ? alu_result_R1[1:0]            : alo_q;
  assign is_load  = (cur_op == LOAD);
  assign is_store = (cur_op == STORE);

  load_store_align u_align (
    .funct3   (cur_f3),
    .addr_lo  (cur_alo),
    .is_store (is_store),
    .rs2      (rs2_data_R1),
    .rdata    (dmem_rdata),
    .be       (be_c),
    .wdata    (wdata_c),
    .misalign (misalign),
    .ld_data  (ld_data)
  );

  // Next-state, request and R2 computation; R2 defaults to a bubble
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    rd_d       = rd_q;
    alo_d      = alo_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    r2_data_d  = '0;
    r2_instr_d = '0;
    r2_rd_d    = '0;
    mis_d      = 1'b0;
    bus_d      = 1'b0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_R1) begin
          if (!(is_load || is_store)) begin
            r2_data_d  = alu_result_R1;
            r2_instr_d = instruction_fetched_R1;
            r2_rd_d    = rd_1;
          end else if (misalign) begin
            mis_d = 1'b1;
          end else begin
            stall   = 1'b1;
            instr_d = instruction_fetched_R1;
            rd_d    = rd_1;
            alo_d   = alu_result_R1[1:0];
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {alu_result_R1[31:2], 2'b00};
            be_d    = be_c;
            wdata_d = wdata_c;
            cnt_d   = '0;
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        stall = 1'b1;
        if (dmem_ack) begin
          req_d      = 1'b0;
          state_d    = IDLE;
          r2_data_d  = we_q ? 32'd0 : ld_data;
          r2_instr_d = instr_q;
          r2_rd_d    = rd_q;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          req_d   = 1'b0;
          bus_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage registers; async reset drops the request immediately
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      instr_q    <= '0;
      rd_q       <= '0;
      alo_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      r2_data_q  <= '0;
      r2_instr_q <= '0;
      r2_rd_q    <= '0;
      mis_q      <= 1'b0;
      bus_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      rd_q       <= rd_d;
      alo_q      <= alo_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      r2_data_q  <= r2_data_d;
      r2_instr_q <= r2_instr_d;
      r2_rd_q    <= r2_rd_d;
      mis_q      <= mis_d;
      bus_q      <= bus_d;
    end
  end

  assign stall_mem              = stall;
  assign dmem_req               = req_q;
  assign dmem_we                = we_q;
  assign dmem_addr              = addr_q;
  assign dmem_wdata             = wdata_q;
  assign dmem_be                = be_q;
  assign data_out_exe_R2        = r2_data_q;
  assign instruction_fetched_R2 = r2_instr_q;
  assign rd_2                   = r2_rd_q;
  assign misalign_err           = mis_q;
  assign bus_err                = bus_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a transaction-level
// model of the load/store rules.
module tb_mem_access;

  localparam int ACK_TIMEOUT = 16;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic        valid_R1;
  logic [31:0] alu_result_R1, rs2_data_R1, instruction_fetched_R1;
  logic [4:0]  rd_1;
  logic        stall_mem, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] data_out_exe_R2, instruction_fetched_R2;
  logic [4:0]  rd_2;
  logic        misalign_err, bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk_100MHz             (clk_100MHz),
    .reset                  (reset),
    .valid_R1               (valid_R1),
    .alu_result_R1          (alu_result_R1),
    .rs2_data_R1            (rs2_data_R1),
    .instruction_fetched_R1 (instruction_fetched_R1),
    .rd_1                   (rd_1),
    .stall_mem              (stall_mem),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_wdata             (dmem_wdata),
    .dmem_be                (dmem_be),
    .dmem_ack               (dmem_ack),
    .dmem_rdata             (dmem_rdata),
    .data_out_exe_R2        (data_out_exe_R2),
    .instruction_fetched_R2 (instruction_fetched_R2),
    .rd_2                   (rd_2),
    .misalign_err           (misalign_err),
    .bus_err                (bus_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[14:12] = f3;
    r[6:0]   = op;
    return r;
  endfunction

  // Reference: decide access legality and the memory-side values from the
  // width/offset rules using plain arithmetic.
  function automatic void model(input logic [31:0] ins, alu, rs2, rdata,
                                output bit mem, output bit mis,
                                output logic [3:0] ebe, output logic [31:0] ewd,
                                output logic [31:0] eld);
    int unsigned op, f3, sz, off;
    bit ld, st, legal;
    logic [31:0] v, m;
    op  = ins[6:0];
    f3  = ins[14:12];
    ld  = (op == 7'h03);
    st  = (op == 7'h23);
    sz  = 1 << (f3 % 4);
    off = alu % 4;
    legal = ld ? (f3 <= 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    mem = (ld || st) && legal && (alu % sz == 0);
    mis = (ld || st) && !mem;
    ebe = st ? 4'(((1 << sz) - 1) << off) : 4'hF;
    ewd = (sz == 1) ? rs2[7:0] * 32'h01010101 :
          (sz == 2) ? rs2[15:0] * 32'h00010001 : rs2;
    v = rdata >> (8 * off);
    if (sz < 4) begin
      m = (32'd1 << (8 * sz)) - 1;
      v = v & m;
      if (f3 < 4 && v[8*sz-1]) v = v | ~m;
    end
    eld = v;
  endfunction

  // Issue one instruction (entered just after a rising edge) and check it
  // through to its R2 result. lat = cycles of req before ack, 0 = never ack.
  task automatic do_op(input logic [31:0] ins, alu, rs2, input logic [4:0] rd,
                       input logic [31:0] rdata, input int lat);
    bit mem, mis, ldst;
    logic [3:0] ebe;
    logic [31:0] ewd, eld;
    int req_n, stall_n, ncyc;
    model(ins, alu, rs2, rdata, mem, mis, ebe, ewd, eld);
    ldst = (ins[6:0] == 7'h03) || (ins[6:0] == 7'h23);
    valid_R1 = 1'b1;
    instruction_fetched_R1 = ins;
    alu_result_R1 = alu;
    rs2_data_R1 = rs2;
    rd_1 = rd;
    if (!mem) dmem_ack = 1'($urandom_range(0, 1));
    @(negedge clk_100MHz);
    chk("stall_issue", 32'(stall_mem), 32'(mem));
    if (!mem) begin
      @(posedge clk_100MHz); #1;
      dmem_ack = 1'b0;
      chk("req_none", 32'(dmem_req), 32'd0);
      chk("misalign_err", 32'(misalign_err), 32'(mis));
      chk("r2_data", data_out_exe_R2, ldst ? 32'd0 : alu);
      chk("r2_instr", instruction_fetched_R2, ldst ? 32'd0 : ins);
      chk("r2_rd", 32'(rd_2), ldst ? 32'd0 : 32'(rd));
      valid_R1 = 1'b0;
    end else begin
      ncyc = (lat == 0) ? ACK_TIMEOUT : lat;
      req_n = 0;
      stall_n = 0;
      for (int n = 0; n < ncyc; n++) begin
        @(posedge clk_100MHz); #1;
        req_n += int'(dmem_req);
        stall_n += int'(stall_mem);
        if (n == 0) begin
          chk("addr", dmem_addr, alu & 32'hFFFF_FFFC);
          chk("be", 32'(dmem_be), 32'(ebe));
          chk("we", 32'(dmem_we), 32'(ins[6:0] == 7'h23));
          if (ins[6:0] == 7'h23) chk("wdata", dmem_wdata, ewd);
          chk("r2_bubble_wait", instruction_fetched_R2, 32'd0);
        end
        dmem_rdata = rdata;
        dmem_ack = (lat != 0) && (n == lat - 1);
      end
      @(posedge clk_100MHz); #1;
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      chk("req_cycles", 32'(req_n), 32'(ncyc));
      chk("stall_cycles", 32'(stall_n), 32'(ncyc));
      chk("req_done", 32'(dmem_req), 32'd0);
      chk("bus_err", 32'(bus_err), 32'(lat == 0));
      chk("misalign_mem", 32'(misalign_err), 32'd0);
      if (lat == 0) begin
        chk("r2_data_to", data_out_exe_R2, 32'd0);
        chk("r2_instr_to", instruction_fetched_R2, 32'd0);
        chk("r2_rd_to", 32'(rd_2), 32'd0);
      end else begin
        chk("r2_data_mem", data_out_exe_R2, (ins[6:0] == 7'h23) ? 32'd0 : eld);
        chk("r2_instr_mem", instruction_fetched_R2, ins);
        chk("r2_rd_mem", 32'(rd_2), 32'(rd));
      end
      valid_R1 = 1'b0;
    end
  endtask

  task automatic do_idle();
    valid_R1 = 1'b0;
    instruction_fetched_R1 = $urandom;
    alu_result_R1 = $urandom;
    dmem_ack = 1'($urandom_range(0, 1));
    @(negedge clk_100MHz);
    chk("stall_idle", 32'(stall_mem), 32'd0);
    @(posedge clk_100MHz); #1;
    dmem_ack = 1'b0;
    chk("bubble_data", data_out_exe_R2, 32'd0);
    chk("bubble_instr", instruction_fetched_R2, 32'd0);
    chk("bubble_req", 32'(dmem_req), 32'd0);
  endtask

  logic [6:0] alu_ops [4] = '{7'h33, 7'h13, 7'h37, 7'h6F};

  initial begin
    reset = 1'b0;
    valid_R1 = 1'b0;
    alu_result_R1 = '0;
    rs2_data_R1 = '0;
    instruction_fetched_R1 = '0;
    rd_1 = '0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    #12;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_data", data_out_exe_R2, 32'd0);
    chk("rst_instr", instruction_fetched_R2, 32'd0);
    chk("rst_rd", 32'(rd_2), 32'd0);
    chk("rst_errs", 32'({misalign_err, bus_err, dmem_we}), 32'd0);
    chk("rst_be_addr", {dmem_addr[27:0], dmem_be}, 32'd0);
    reset = 1'b1;
    @(posedge clk_100MHz); #1;

    // Directed cases
    do_op(32'h002081B3, 32'h1234, 32'h0, 5'd3, 32'h0, 1);
    do_op({12'h0, 5'd1, 3'b000, 5'd5, 7'b0000011}, 32'h103, 32'h0, 5'd5, 32'h80FFFFFF, 3);
    do_op({7'h0, 5'd2, 5'd1, 3'b001, 5'd0, 7'b0100011}, 32'h202, 32'hABCD1234, 5'd0, 32'h0, 1);
    do_op(mk(7'h03, 3'b010), 32'h101, 32'h0, 5'd7, 32'h0, 1);
    do_op(mk(7'h03, 3'b010), 32'h40, 32'h0, 5'd9, 32'h0, 0);
    do_op(32'h002081B3, 32'h5678, 32'h0, 5'd3, 32'h0, 1);
    do_op(mk(7'h23, 3'b100), 32'h200, 32'h11, 5'd4, 32'h0, 1);
    do_op(mk(7'h03, 3'b110), 32'h200, 32'h0, 5'd4, 32'h0, 1);

    // Reset in the middle of a pending access
    valid_R1 = 1'b1;
    instruction_fetched_R1 = mk(7'h03, 3'b010);
    alu_result_R1 = 32'h80;
    rd_1 = 5'd6;
    @(posedge clk_100MHz); #1;
    @(posedge clk_100MHz); #1;
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    valid_R1 = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_data", data_out_exe_R2, 32'd0);
    chk("midrst_instr", instruction_fetched_R2, 32'd0);
    chk("midrst_rd", 32'(rd_2), 32'd0);
    @(negedge clk_100MHz);
    reset = 1'b1;
    @(posedge clk_100MHz); #1;
    do_op(32'h00B50533, 32'hCAFE, 32'h0, 5'd10, 32'h0, 1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int kind;
      int lat;
      kind = $urandom_range(0, 9);
      lat  = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 5);
      if (kind <= 2)
        do_op(mk(alu_ops[$urandom_range(0, 3)], 3'($urandom)), $urandom, $urandom,
              5'($urandom), $urandom, 1);
      else if (kind <= 5)
        do_op(mk(7'h03, 3'($urandom)), $urandom, $urandom, 5'($urandom), $urandom, lat);
      else if (kind <= 8)
        do_op(mk(7'h23, 3'($urandom)), $urandom, $urandom, 5'($urandom), $urandom, lat);
      else
        do_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage of the RISC-V pipeline, between execute and write-back.
- Drives the three R2 signals that write-back consumes: `data_out_exe_R2`, `instruction_fetched_R2` and `rd_2`.
- Passes ALU results through with 1-cycle latency.
- Performs LOAD/STORE through a req/ack data-memory handshake, stalling upstream until the access completes.

Parameters:
- ACK_TIMEOUT, 16: max cycles in WAIT_ACK before the access is aborted.
- CNT_W, $clog2(ACK_TIMEOUT+1): width of the timeout counter.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- valid_R1  in  1  execute-stage result valid.
- alu_result_R1  in  32  ALU result; effective address for LOAD/STORE.
- rs2_data_R1  in  32  store data.
- instruction_fetched_R1  in  32  instruction from execute.
- rd_1  in  5  destination register.
- stall_mem  out  1  hold upstream inputs while high.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1=store, 0=load.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle.
- dmem_rdata  in  32  read word.
- data_out_exe_R2  out  32  result to write-back.
- instruction_fetched_R2  out  32  instruction to write-back.
- rd_2  out  5  destination to write-back.
- misalign_err  out  1  1-cycle pulse on a misaligned access.
- bus_err  out  1  1-cycle pulse on a timeout.

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, counter 0.
- Bubble = instruction_fetched_R2=0, data_out_exe_R2=0, rd_2=0. Opcode 0 causes no write in write-back.
- Opcode = instruction_fetched_R1[6:0]; funct3 = [14:12]; addr = alu_result_R1.
- IDLE, valid_R1=0: R2 <= bubble.
- IDLE, valid_R1=1, opcode not LOAD/STORE: R2 <= {alu_result_R1, instruction_fetched_R1, rd_1} at the next edge; stall_mem=0.
- IDLE, LOAD/STORE, misaligned (H: addr[0]=1; W: addr[1:0]!=0):
  - no request;
  - misalign_err=1 for one cycle;
  - R2 <= bubble;
  - stall_mem=0; instruction consumed.
- IDLE, LOAD/STORE, aligned:
  - stall_mem=1 combinationally this cycle;
  - latch instruction, rd and addr[1:0];
  - at the edge, register dmem_req=1, dmem_we, dmem_addr, dmem_be, dmem_wdata;
  - R2 <= bubble; counter <= 0; go to WAIT_ACK.
- Store byte enables: SB be=4'b0001<<addr[1:0]; SH be=4'b0011<<addr[1:0]; SW be=4'b1111. Load be=4'b1111.
- Store wdata: SB {4{rs2[7:0]}}; SH {2{rs2[15:0]}}; SW rs2.
- WAIT_ACK: stall_mem=1; request signals held stable; R2 holds bubble.
  - dmem_ack=1: at the edge, dmem_req <= 0 and return to IDLE.
    - LOAD: data_out_exe_R2 <= selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU); LW passes the word.
    - STORE: data_out_exe_R2 <= 0; instruction and rd still forwarded; write-back ignores STORE.
  - dmem_ack=0: counter increments. At counter==ACK_TIMEOUT-1 without ack:
    - dmem_req <= 0;
    - bus_err pulses one cycle;
    - R2 <= bubble; return to IDLE.
  - Ack on the timeout cycle: ack wins.
- stall_mem deasserts the cycle after ack/timeout; the next instruction is accepted then.
- dmem_ack outside WAIT_ACK is ignored.
- Unsupported funct3 on LOAD/STORE (e.g. 011, 110, 111): treated as misaligned (misalign_err, bubble).
- Latency: ALU op 1 cycle; memory op 1 + (cycles until ack).
- Reset mid-WAIT_ACK: dmem_req drops immediately (async); nothing is forwarded.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants R_TYPE=7'b0110011, I_TYPE=7'b0010011, LOAD=7'b0000011, STORE=7'b0100011 (write-back also uses these);
  - funct3 width encodings (B=000, H=001, W=010, BU=100, HU=101);
  - state enum {IDLE, WAIT_ACK}.
- One combinational sub-module, load_store_align, computes be, wdata, the misalign flag and the extended load data from funct3, addr[1:0], rs2 and rdata.

Test Plan:
- ADD pass-through: valid_R1=1, instr=32'h002081B3, alu_result=32'h1234, rd_1=3 -> next cycle R2={32'h1234, 32'h002081B3, 3}; stall_mem never high.
- LB sign-extend: addr=32'h103, rdata=32'h80FFFFFF, ack 3 cycles after req -> dmem_addr=32'h100, be=4'hF, stall high 4 cycles, data_out_exe_R2=32'hFFFFFF80.
- SH upper half: addr=32'h202, rs2=32'hABCD1234, ack immediate -> be=4'b1100, wdata=32'h12341234, dmem_we=1, data_out_exe_R2=0, instruction forwarded.
- LW misaligned: addr=32'h101 -> no dmem_req, misalign_err one cycle, R2 bubble, stall_mem=0.
- Timeout: LW addr=32'h40, ack never -> dmem_req high exactly ACK_TIMEOUT cycles, bus_err pulse, bubble, next ALU op accepted the following cycle.
- Reset asserted mid-WAIT_ACK -> dmem_req=0 immediately, all R2 outputs 0, IDLE after release.
